alu_seq: RTL and testbench
==========================

// Module: alu_seq
// PURPOSE
//  Multi-cycle successor to the combinational EX-stage ALU, with a registered result and a valid/ready handshake.
//  Adds shifts, signed/unsigned compares, and iterative MUL/MULHU/DIVU/REMU.
//  Sits in EX; the hazard unit stalls IF/ID/EX while in_ready=0 and flushes the block on branch mispredict.
// PARAMETERS
//  DATA_WIDTH     32  operand/result width; even, >=8
//  OPCODE_LENGTH  5   Operation width; bit4 selects the mul/div group
// PORTS
//  clk        in   1           rising-edge clock
//  rst_n      in   1           asynchronous active-low reset
//  in_valid   in   1           operands/Operation valid
//  in_ready   out  1           block can accept a new operation
//  SrcA       in   DATA_WIDTH  operand A
//  SrcB       in   DATA_WIDTH  operand B
//  Operation  in   5           opcode, see BEHAVIOUR
//  flush      in   1           kill in-flight operation
//  out_valid  out  1           ALUResult valid
//  out_ready  in   1           consumer takes result
//  ALUResult  out  DATA_WIDTH  registered result
//  illegal    out  1           qualified by out_valid; opcode unsupported
// BEHAVIOUR
//  Opcodes:
//   00000 AND, 00001 OR, 00010 ADD, 00011 SUB, 00100 XOR, 00101 SLL, 00110 SRL, 00111 SRA,
//   01000 EQ, 01001 NE, 01010 LT(s), 01011 GE(s), 01100 LTU, 01101 GEU,
//   10000 MUL(low), 10001 MULHU, 10010 DIVU, 10011 REMU; all others are illegal.
//  Arithmetic rules:
//   - ADD/SUB wrap modulo 2^DATA_WIDTH.
//   - Shift amount = SrcB[$clog2(DATA_WIDTH)-1:0].
//   - Compares return 1 or 0, zero-extended.
//  FSM states: IDLE, BUSY, DONE. Accept = in_valid && in_ready && !flush.
//   - IDLE: on accept of a single-cycle or illegal op, register the result and go to DONE. Latency 1: out_valid in the cycle after accept.
//   - IDLE: on accept of a mul/div op, latch operands, load cnt=DATA_WIDTH, go to BUSY.
//   - BUSY: one radix-2 step per cycle (shift-add for MUL/MULHU, restoring for DIVU/REMU); cnt decrements.
//   - BUSY -> DONE when cnt reaches 0. Accept at cycle 0 gives out_valid at cycle DATA_WIDTH+1.
//   - DONE: out_valid=1; ALUResult/illegal are held stable until out_ready.
//   - DONE with out_ready: if a new accept occurs the same cycle, take the IDLE transition for it; otherwise go to IDLE.
//  in_ready = (state==IDLE) || (state==DONE && out_ready).
//  MUL returns the low DATA_WIDTH bits of the 2*DATA_WIDTH-bit unsigned product; MULHU returns the high bits.
//  Divide by zero (DIVU/REMU): quotient all-ones, remainder = SrcA, 33-cycle latency unchanged. No exception is raised.
//  flush:
//   - Any state goes to IDLE next cycle; out_valid=0 and cnt=0.
//   - flush wins over a simultaneous in_valid (nothing is accepted) and over out_ready (the result is dropped).
//  Reset (async, any state, including mid-BUSY): state=IDLE, cnt=0, out_valid=0, ALUResult=0, illegal=0, internal operand regs=0.
//   After reset deasserts, in_ready=1 in the first cycle.
//  ALUResult and illegal never change while out_valid=1 && !out_ready.
// CONFIGURATION
//  `ALU_MULDIV_EN defined: mul/div datapath, counter and BUSY state are built; behaviour as above.
//  `ALU_MULDIV_EN undefined:
//   - No multiplier/divider logic; BUSY is unreachable.
//   - Opcodes 10000-10011 are treated as illegal: ALUResult=0, illegal=1, latency 1.
//   - Single-cycle ops are unchanged.
// TESTING
//  1. ADD 0x7FFFFFFF,0x00000001 -> next cycle out_valid=1, ALUResult=0x80000000, illegal=0.
//  2. SRA 0x80000000,SrcB=0x24 -> 0xF8000000; SLTU-style LTU 0x00000001,0xFFFFFFFF -> 1; LT same operands -> 0.
//  3. MUL 0xFFFFFFFF,2 -> 0xFFFFFFFE at cycle 33; MULHU same -> 0x00000001; in_ready=0 during cycles 1-32.
//  4. DIVU 100,7 -> 14; REMU 100,7 -> 2; DIVU 5,0 -> 0xFFFFFFFF; REMU 5,0 -> 5.
//  5. Hold out_ready=0 for 5 cycles after a result -> ALUResult stable and in_ready=0; then out_ready=1 with a new in_valid (ADD) -> accepted the same cycle.
//  6. Start DIVU, then assert flush at cycle 10 -> out_valid stays 0, in_ready=1 next cycle.
//     Repeat with rst_n low at cycle 10 -> all outputs 0 immediately.
//     Without `ALU_MULDIV_EN: MUL -> illegal=1, ALUResult=0 after 1 cycle.

Source files
------------

// File: rtl/alu_seq.sv
// alu_seq: multi-cycle EX-stage ALU with a registered result and valid/ready handshake.
// Single-cycle ops (logic, add/sub, shifts, compares) complete with latency 1.
// Optional feature macro: ALU_MULDIV_EN builds the iterative MUL/MULHU/DIVU/REMU
// datapath (radix-2, DATA_WIDTH steps). Without it those opcodes report illegal.
//
// Handshake: an operation is accepted on a rising edge where in_valid && in_ready
// && !flush. A result is consumed on a rising edge where out_valid && out_ready.
// ALUResult/illegal are stable while out_valid && !out_ready. flush drops everything.
module alu_seq #(
  parameter int DATA_WIDTH    = 32,
  parameter int OPCODE_LENGTH = 5
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [DATA_WIDTH-1:0]    SrcA,
  input  logic [DATA_WIDTH-1:0]    SrcB,
  input  logic [OPCODE_LENGTH-1:0] Operation,
  input  logic                     flush,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATA_WIDTH-1:0]    ALUResult,
  output logic                     illegal,
  output logic [1:0]               dbg_state_o
);

  localparam int SHW = $clog2(DATA_WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e                  state_q;
  logic                    out_valid_q;
  logic                    illegal_q;
  logic [DATA_WIDTH-1:0]   result_q;

  logic                    accept;
  logic [SHW-1:0]          shamt;
  logic [DATA_WIDTH-1:0]   sc_res_d;
  logic                    sc_ill_d;

  assign in_ready    = (state_q == IDLE) || ((state_q == DONE) && out_ready);
  assign accept      = in_valid && in_ready && !flush;
  assign shamt       = SrcB[SHW-1:0];
  assign out_valid   = out_valid_q;
  assign ALUResult   = result_q;
  assign illegal     = illegal_q;
  assign dbg_state_o = state_q;

`ifdef ALU_MULDIV_EN
  localparam int CW = $clog2(DATA_WIDTH + 1);

  // hi/lo hold {accumulator, multiplier} for MUL* and {remainder, quotient} for DIV*.
  logic [CW-1:0]           cnt_q;
  logic [1:0]              md_op_q;
  logic [DATA_WIDTH-1:0]   a_q;
  logic [DATA_WIDTH-1:0]   b_q;
  logic [DATA_WIDTH-1:0]   hi_q;
  logic [DATA_WIDTH-1:0]   lo_q;
  logic [DATA_WIDTH-1:0]   hi_d;
  logic [DATA_WIDTH-1:0]   lo_d;
  logic [DATA_WIDTH-1:0]   md_res_d;
  logic [DATA_WIDTH:0]     mul_sum;
  logic [DATA_WIDTH:0]     rem_sh;
  logic                    start_md;

  // One radix-2 step: shift-add multiply or restoring divide.
  always_comb begin
    mul_sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, a_q} : '0);
    rem_sh  = {hi_q, lo_q[DATA_WIDTH-1]};
    hi_d    = hi_q;
    lo_d    = lo_q;
    if (!md_op_q[1]) begin
      hi_d = mul_sum[DATA_WIDTH:1];
      lo_d = {mul_sum[0], lo_q[DATA_WIDTH-1:1]};
    end else if (rem_sh >= {1'b0, b_q}) begin
      // Partial remainder is below the divisor afterwards, so the low bits suffice.
      hi_d = rem_sh[DATA_WIDTH-1:0] - b_q;
      lo_d = {lo_q[DATA_WIDTH-2:0], 1'b1};
    end else begin
      hi_d = rem_sh[DATA_WIDTH-1:0];
      lo_d = {lo_q[DATA_WIDTH-2:0], 1'b0};
    end
    // MUL and DIVU take the low half, MULHU and REMU the high half.
    md_res_d = md_op_q[0] ? hi_d : lo_d;
  end
`endif

  // Single-cycle result and opcode decode.
  always_comb begin
    sc_res_d = '0;
    sc_ill_d = 1'b0;
`ifdef ALU_MULDIV_EN
    start_md = 1'b0;
`endif
    case (Operation)
      5'b00000: sc_res_d = SrcA & SrcB;
      5'b00001: sc_res_d = SrcA | SrcB;
      5'b00010: sc_res_d = SrcA + SrcB;
      5'b00011: sc_res_d = SrcA - SrcB;
      5'b00100: sc_res_d = SrcA ^ SrcB;
      5'b00101: sc_res_d = SrcA << shamt;
      5'b00110: sc_res_d = SrcA >> shamt;
      5'b00111: sc_res_d = $signed(SrcA) >>> shamt;
      5'b01000: sc_res_d = {{(DATA_WIDTH-1){1'b0}}, (SrcA == SrcB)};
      5'b01001: sc_res_d = {{(DATA_WIDTH-1){1'b0}}, (SrcA != SrcB)};
      5'b01010: sc_res_d = {{(DATA_WIDTH-1){1'b0}}, ($signed(SrcA) < $signed(SrcB))};
      5'b01011: sc_res_d = {{(DATA_WIDTH-1){1'b0}}, ($signed(SrcA) >= $signed(SrcB))};
      5'b01100: sc_res_d = {{(DATA_WIDTH-1){1'b0}}, (SrcA < SrcB)};
      5'b01101: sc_res_d = {{(DATA_WIDTH-1){1'b0}}, (SrcA >= SrcB)};
`ifdef ALU_MULDIV_EN
      5'b10000, 5'b10001, 5'b10010, 5'b10011: start_md = 1'b1;
`endif
      default:  sc_ill_d = 1'b1;
    endcase
  end

  // Control FSM with registered outputs; flush and reset both return to IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      illegal_q   <= 1'b0;
`ifdef ALU_MULDIV_EN
      cnt_q       <= '0;
      md_op_q     <= '0;
      a_q         <= '0;
      b_q         <= '0;
      hi_q        <= '0;
      lo_q        <= '0;
`endif
    end else if (flush) begin
      state_q     <= IDLE;
      out_valid_q <= 1'b0;
`ifdef ALU_MULDIV_EN
      cnt_q       <= '0;
`endif
    end else begin
      case (state_q)
`ifdef ALU_MULDIV_EN
        BUSY: begin
          hi_q  <= hi_d;
          lo_q  <= lo_d;
          cnt_q <= cnt_q - CW'(1);
          if (cnt_q == CW'(1)) begin
            state_q     <= DONE;
            out_valid_q <= 1'b1;
            result_q    <= md_res_d;
            illegal_q   <= 1'b0;
          end
        end
`endif
        default: begin
          // IDLE and DONE share the accept path; DONE first retires its result.
          if ((state_q == DONE) && out_ready) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
          end
          if (accept) begin
`ifdef ALU_MULDIV_EN
            if (start_md) begin
              state_q     <= BUSY;
              out_valid_q <= 1'b0;
              cnt_q       <= CW'(DATA_WIDTH);
              md_op_q     <= Operation[1:0];
              a_q         <= SrcA;
              b_q         <= SrcB;
              hi_q        <= '0;
              lo_q        <= Operation[1] ? SrcA : SrcB;
            end else
`endif
            begin
              state_q     <= DONE;
              out_valid_q <= 1'b1;
              result_q    <= sc_res_d;
              illegal_q   <= sc_ill_d;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: bench for alu_seq (DATA_WIDTH=32). Honours ALU_MULDIV_EN the same way
// as the design: mul/div expectations switch between real results and illegal.
`timescale 1ns/1ps
module tb_alu_seq;
  localparam int W = 32;
`ifdef ALU_MULDIV_EN
  localparam bit MD_EN = 1'b1;
`else
  localparam bit MD_EN = 1'b0;
`endif

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] SrcA;
  logic [W-1:0] SrcB;
  logic [4:0]   Operation;
  logic         flush;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] ALUResult;
  logic         illegal;
  logic [1:0]   dbg_state;

  int n_checks = 0;
  int n_fail   = 0;

  logic [W-1:0] exp_q[$];
  logic         exp_ill_q[$];

  typedef struct {
    logic [4:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] res;
    logic         ill;
  } vec_t;

  vec_t vecs[25];

  alu_seq #(.DATA_WIDTH(W), .OPCODE_LENGTH(5)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .SrcA(SrcA), .SrcB(SrcB), .Operation(Operation), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .ALUResult(ALUResult),
    .illegal(illegal), .dbg_state_o(dbg_state)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Independent reference for random stimulus.
  function automatic void ref_alu(input logic [4:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                                  output logic [W-1:0] r, output logic il);
    logic [2*W-1:0] p;
    p  = {{W{1'b0}}, a} * {{W{1'b0}}, b};
    r  = '0;
    il = 1'b0;
    case (op)
      5'd0:  r = a & b;
      5'd1:  r = a | b;
      5'd2:  r = a + b;
      5'd3:  r = a - b;
      5'd4:  r = a ^ b;
      5'd5:  r = a << b[4:0];
      5'd6:  r = a >> b[4:0];
      5'd7:  r = $signed(a) >>> b[4:0];
      5'd8:  r = (a == b) ? 32'd1 : 32'd0;
      5'd9:  r = (a != b) ? 32'd1 : 32'd0;
      5'd10: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      5'd11: r = ($signed(a) >= $signed(b)) ? 32'd1 : 32'd0;
      5'd12: r = (a < b) ? 32'd1 : 32'd0;
      5'd13: r = (a >= b) ? 32'd1 : 32'd0;
      5'd16: begin r = MD_EN ? p[W-1:0] : '0;   il = !MD_EN; end
      5'd17: begin r = MD_EN ? p[2*W-1:W] : '0; il = !MD_EN; end
      5'd18: begin r = !MD_EN ? '0 : (b == 0) ? '1 : a / b; il = !MD_EN; end
      5'd19: begin r = !MD_EN ? '0 : (b == 0) ? a : a % b;  il = !MD_EN; end
      default: il = 1'b1;
    endcase
  endfunction

  // Driver: present an op, wait for in_ready, record expectation, drop in_valid after accept.
  task automatic issue(input logic [4:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [W-1:0] er, input logic ei, input bit push);
    int guard;
    guard     = 0;
    in_valid  = 1'b1;
    Operation = op;
    SrcA      = a;
    SrcB      = b;
    @(negedge clk);
    while (!in_ready && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    if (!in_ready) begin
      check("issue_timeout_in_ready", {31'd0, in_ready}, 32'd1);
    end else if (push) begin
      exp_q.push_back(er);
      exp_ill_q.push_back(ei);
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  // Scoreboard: compare each consumed result against the oldest expectation.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready && !flush) begin
      if (exp_q.size() == 0) begin
        check("unexpected_result", ALUResult, 32'hDEAD_0000);
      end else begin
        check("sb_result", ALUResult, exp_q.pop_front());
        check("sb_illegal", {31'd0, illegal}, {31'd0, exp_ill_q.pop_front()});
      end
    end
  end

  initial begin
    logic [W-1:0] r;
    logic         il;
    logic [4:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    bit           busy_ok;
    bit           any_valid;
    int           g;

    vecs[0]  = '{5'b00010, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b0};
    vecs[1]  = '{5'b00011, 32'h00000000, 32'h00000001, 32'hFFFFFFFF, 1'b0};
    vecs[2]  = '{5'b00000, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 1'b0};
    vecs[3]  = '{5'b00001, 32'hF0F0F0F0, 32'h0F0F0000, 32'hFFFFF0F0, 1'b0};
    vecs[4]  = '{5'b00100, 32'hFFFF0000, 32'h0F0F0F0F, 32'hF0F00F0F, 1'b0};
    vecs[5]  = '{5'b00101, 32'h00000001, 32'h00000021, 32'h00000002, 1'b0};
    vecs[6]  = '{5'b00110, 32'h80000000, 32'h0000001F, 32'h00000001, 1'b0};
    vecs[7]  = '{5'b00111, 32'h80000000, 32'h00000024, 32'hF8000000, 1'b0};
    vecs[8]  = '{5'b01000, 32'h00000005, 32'h00000005, 32'h00000001, 1'b0};
    vecs[9]  = '{5'b01001, 32'h00000005, 32'h00000005, 32'h00000000, 1'b0};
    vecs[10] = '{5'b01010, 32'h00000001, 32'hFFFFFFFF, 32'h00000000, 1'b0};
    vecs[11] = '{5'b01011, 32'h00000001, 32'hFFFFFFFF, 32'h00000001, 1'b0};
    vecs[12] = '{5'b01100, 32'h00000001, 32'hFFFFFFFF, 32'h00000001, 1'b0};
    vecs[13] = '{5'b01101, 32'h00000001, 32'hFFFFFFFF, 32'h00000000, 1'b0};
    vecs[14] = '{5'b01010, 32'h80000000, 32'h00000000, 32'h00000001, 1'b0};
    vecs[15] = '{5'b01110, 32'h12345678, 32'h00000001, 32'h00000000, 1'b1};
    vecs[16] = '{5'b11111, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 1'b1};
    vecs[17] = '{5'b10000, 32'hFFFFFFFF, 32'h00000002, MD_EN ? 32'hFFFFFFFE : 32'h0, !MD_EN};
    vecs[18] = '{5'b10001, 32'hFFFFFFFF, 32'h00000002, MD_EN ? 32'h00000001 : 32'h0, !MD_EN};
    vecs[19] = '{5'b10010, 32'd100,      32'd7,        MD_EN ? 32'd14 : 32'h0,        !MD_EN};
    vecs[20] = '{5'b10011, 32'd100,      32'd7,        MD_EN ? 32'd2 : 32'h0,         !MD_EN};
    vecs[21] = '{5'b10010, 32'd5,        32'd0,        MD_EN ? 32'hFFFFFFFF : 32'h0, !MD_EN};
    vecs[22] = '{5'b10011, 32'd5,        32'd0,        MD_EN ? 32'd5 : 32'h0,         !MD_EN};
    vecs[23] = '{5'b10001, 32'hFFFFFFFF, 32'hFFFFFFFF, MD_EN ? 32'hFFFFFFFE : 32'h0, !MD_EN};
    vecs[24] = '{5'b10000, 32'h12345678, 32'd9,        MD_EN ? 32'hA3D70A38 : 32'h0, !MD_EN};

    rst_n = 1'b0; in_valid = 1'b0; SrcA = '0; SrcB = '0; Operation = '0;
    flush = 1'b0; out_ready = 1'b1;
    #2;
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_result", ALUResult, 32'd0);
    check("rst_illegal", {31'd0, illegal}, 32'd0);
    check("rst_state", {30'd0, dbg_state}, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("in_ready_after_rst", {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1;

    // Table-driven vectors, back-to-back with out_ready held high.
    for (int i = 0; i < 25; i++) begin
      issue(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].res, vecs[i].ill, 1'b1);
    end

    // Random vectors checked against the reference model.
    for (int i = 0; i < 30; i++) begin
      if (MD_EN && $urandom_range(0, 3) == 0) op = 5'(16 + $urandom_range(0, 3));
      else                                     op = 5'($urandom_range(0, 15));
      a = $urandom;
      b = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
      ref_alu(op, a, b, r, il);
      issue(op, a, b, r, il, 1'b1);
    end

    // Latency 1 for a single-cycle op.
    issue(5'b00010, 32'h7FFFFFFF, 32'h1, 32'h80000000, 1'b0, 1'b1);
    check("lat1_out_valid", {31'd0, out_valid}, 32'd1);
    check("lat1_result", ALUResult, 32'h80000000);
    @(posedge clk); #1;

    // Back-pressure: result held for 5 cycles, then new op accepted as it retires.
    out_ready = 1'b0;
    issue(5'b00100, 32'hF0F0F0F0, 32'h0F0F0F0F, 32'hFFFFFFFF, 1'b0, 1'b1);
    for (int k = 0; k < 5; k++) begin
      check("hold_out_valid", {31'd0, out_valid}, 32'd1);
      check("hold_result", ALUResult, 32'hFFFFFFFF);
      check("hold_in_ready", {31'd0, in_ready}, 32'd0);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    issue(5'b00010, 32'd3, 32'd4, 32'd7, 1'b0, 1'b1);
    check("same_cycle_accept_result", ALUResult, 32'd7);
    check("same_cycle_accept_valid", {31'd0, out_valid}, 32'd1);
    @(posedge clk); #1;

`ifdef ALU_MULDIV_EN
    // Multi-cycle latency: out_valid at cycle DATA_WIDTH+1, in_ready low while busy.
    issue(5'b10000, 32'hFFFFFFFF, 32'd2, 32'hFFFFFFFE, 1'b0, 1'b1);
    busy_ok = 1'b1;
    for (int k = 1; k <= 32; k++) begin
      if (out_valid || in_ready) busy_ok = 1'b0;
      @(posedge clk); #1;
    end
    check("mul_busy_window", {31'd0, busy_ok}, 32'd1);
    check("mul_lat33_valid", {31'd0, out_valid}, 32'd1);
    check("mul_lat33_result", ALUResult, 32'hFFFFFFFE);
    @(posedge clk); #1;

    // Flush mid-divide at cycle 10.
    issue(5'b10010, 32'd100, 32'd7, 32'd0, 1'b0, 1'b0);
    repeat (9) @(posedge clk);
    #1 flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    check("div_flush_out_valid", {31'd0, out_valid}, 32'd0);
    check("div_flush_in_ready", {31'd0, in_ready}, 32'd1);
    any_valid = 1'b0;
    for (int k = 0; k < 30; k++) begin
      @(posedge clk); #1;
      if (out_valid) any_valid = 1'b1;
    end
    check("div_flush_no_result", {31'd0, any_valid}, 32'd0);

    // Reset mid-divide at cycle 10: outputs clear without a clock edge.
    check("pre_reset_result", ALUResult, 32'hFFFFFFFE);
    issue(5'b10010, 32'd100, 32'd7, 32'd0, 1'b0, 1'b0);
    repeat (9) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("busy_rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("busy_rst_result", ALUResult, 32'd0);
    check("busy_rst_illegal", {31'd0, illegal}, 32'd0);
    check("busy_rst_in_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
`else
    // Mul/div opcodes are illegal with latency 1 when the datapath is absent.
    issue(5'b10000, 32'hFFFFFFFF, 32'd2, 32'd0, 1'b1, 1'b1);
    check("nomd_mul_valid", {31'd0, out_valid}, 32'd1);
    check("nomd_mul_illegal", {31'd0, illegal}, 32'd1);
    check("nomd_mul_result", ALUResult, 32'd0);
    @(posedge clk); #1;
`endif

    // flush wins over a simultaneous in_valid and over out_ready.
    out_ready = 1'b0;
    issue(5'b00010, 32'd5, 32'd6, 32'd0, 1'b0, 1'b0);
    check("flush_pre_valid", {31'd0, out_valid}, 32'd1);
    out_ready = 1'b1; flush = 1'b1; in_valid = 1'b1;
    Operation = 5'b00001; SrcA = 32'h1; SrcB = 32'h2;
    @(posedge clk);
    #1 flush = 1'b0; in_valid = 1'b0;
    check("flush_out_valid", {31'd0, out_valid}, 32'd0);
    check("flush_in_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1;
    check("flush_nothing_accepted", {31'd0, out_valid}, 32'd0);

    // Async reset while a result is waiting.
    out_ready = 1'b0;
    issue(5'b00010, 32'd5, 32'd6, 32'd0, 1'b0, 1'b0);
    check("done_pre_rst_result", ALUResult, 32'd11);
    #2 rst_n = 1'b0;
    #1;
    check("done_rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("done_rst_result", ALUResult, 32'd0);
    check("done_rst_illegal", {31'd0, illegal}, 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    check("in_ready_after_rst2", {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1;

    g = 0;
    while (exp_q.size() != 0 && g < 200) begin
      @(posedge clk);
      g++;
    end
    check("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
